// File: rtl/inv_resp_checker.sv
// Response checker for the inverter datapath: compares each accepted (a, y) pair against y == ~a.
// Optional INV_CHK_ABORT_EN ends the run on the first mismatching pair.
module inv_resp_checker #(
  parameter int WIDTH       = 1,
  parameter int NUM_VECTORS = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic             first_fail_valid
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

  state_t           state;
  logic [CNT_W-1:0] idx;
  logic             accept;
  logic             mismatch;
  logic             run_end;
  logic [CNT_W-1:0] err_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign accept   = s_valid && s_ready;
  assign mismatch = (y_in != ~a_in);
  assign err_next = mismatch ? sat_inc(err_count) : err_count;

`ifdef INV_CHK_ABORT_EN
  assign run_end = (idx == LAST_IDX) || mismatch;
`else
  assign run_end = (idx == LAST_IDX);
`endif

  // s_ready is held in a register so it never depends on s_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      idx              <= '0;
      s_ready          <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_idx   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state            <= RUN;
            idx              <= '0;
            s_ready          <= 1'b1;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
          end
        end
        RUN: begin
          if (accept) begin
            idx       <= idx + CNT_W'(1);
            err_count <= err_next;
            if (mismatch && !first_fail_valid) begin
              first_fail_idx   <= idx;
              first_fail_valid <= 1'b1;
            end
            // Completion flags land on the same edge that takes the final pair.
            if (run_end) begin
              state   <= DONE;
              s_ready <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (err_next == '0);
            end
          end
        end
        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_resp_checker.sv
// Bench for inv_resp_checker: three configurations checked every cycle against a run-level model.
// Honours INV_CHK_ABORT_EN when the design is built with it.
module tb_inv_resp_checker;

`ifdef INV_CHK_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_t[3], start_t[3], valid_t[3];
  logic [3:0] a_t[3], y_t[3];
  logic       s_ready[3], busy[3], done[3], pass[3], ffv[3];
  logic [7:0] err01[2], ffi01[2];
  logic [1:0] err2, ffi2;

  inv_resp_checker #(.WIDTH(1), .NUM_VECTORS(2), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst_t[0]), .start(start_t[0]), .a_in(a_t[0][0:0]), .y_in(y_t[0][0:0]),
    .s_valid(valid_t[0]), .s_ready(s_ready[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_count(err01[0]), .first_fail_idx(ffi01[0]), .first_fail_valid(ffv[0]));

  inv_resp_checker #(.WIDTH(4), .NUM_VECTORS(3), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst_t[1]), .start(start_t[1]), .a_in(a_t[1]), .y_in(y_t[1]),
    .s_valid(valid_t[1]), .s_ready(s_ready[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_count(err01[1]), .first_fail_idx(ffi01[1]), .first_fail_valid(ffv[1]));

  inv_resp_checker #(.WIDTH(1), .NUM_VECTORS(3), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst_t[2]), .start(start_t[2]), .a_in(a_t[2][0:0]), .y_in(y_t[2][0:0]),
    .s_valid(valid_t[2]), .s_ready(s_ready[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
    .err_count(err2), .first_fail_idx(ffi2), .first_fail_valid(ffv[2]));

  // Model: run phase (0 idle, 1 running, 2 finished), pairs taken, mismatches, first bad index.
  int ph[3], nacc[3], nmis[3], first[3];
  int nvec[3] = '{2, 3, 3};
  int wid[3]  = '{1, 4, 1};
  int emax[3] = '{255, 255, 3};
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  function automatic logic [7:0] get_err(input int k);
    case (k)
      0: return err01[0];
      1: return err01[1];
      default: return {6'b0, err2};
    endcase
  endfunction

  function automatic logic [7:0] get_ffi(input int k);
    case (k)
      0: return ffi01[0];
      1: return ffi01[1];
      default: return {6'b0, ffi2};
    endcase
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s u%0d cyc=%0d got=%0d exp=%0d", nm, k, cyc, got, exp);
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      if (rst_t[k]) begin
        ph[k] = 0; nacc[k] = 0; nmis[k] = 0; first[k] = -1;
      end else if (ph[k] != 1 && start_t[k]) begin
        ph[k] = 1; nacc[k] = 0; nmis[k] = 0; first[k] = -1;
      end else if (ph[k] == 1 && valid_t[k]) begin
        int mask;
        bit mis;
        mask = (1 << wid[k]) - 1;
        mis  = ((int'(a_t[k] ^ y_t[k]) & mask) != mask);
        if (mis) begin
          if (first[k] < 0) first[k] = nacc[k];
          nmis[k]++;
        end
        nacc[k]++;
        if (nacc[k] == nvec[k] || (ABORT && mis)) ph[k] = 2;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      int ec;
      ec = (nmis[k] > emax[k]) ? emax[k] : nmis[k];
      chk("s_ready", k, s_ready[k], ph[k] == 1);
      chk("busy", k, busy[k], ph[k] == 1);
      chk("done", k, done[k], ph[k] == 2);
      chk("pass", k, pass[k], (ph[k] == 2) && (nmis[k] == 0));
      chk("err_count", k, get_err(k), ec);
      chk("first_fail_valid", k, ffv[k], first[k] >= 0);
      chk("first_fail_idx", k, get_ffi(k), (first[k] >= 0) ? first[k] : 0);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    cyc++;
    check_all();
  endtask

  task automatic pair(input int k, input logic [3:0] a, input logic [3:0] y);
    valid_t[k] = 1'b1; a_t[k] = a; y_t[k] = y;
    cycle();
    valid_t[k] = 1'b0;
  endtask

  task automatic pulse_start(input int k);
    start_t[k] = 1'b1;
    cycle();
    start_t[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_t[k] = 1'b1; start_t[k] = 1'b0; valid_t[k] = 1'b0; a_t[k] = '0; y_t[k] = '0;
      ph[k] = 0; nacc[k] = 0; nmis[k] = 0; first[k] = -1;
    end
    #2;
    cycle();
    cycle();
    for (int k = 0; k < 3; k++) rst_t[k] = 1'b0;
    chk("rst_done", 0, done[0], 0);
    chk("rst_ready", 1, s_ready[1], 0);
    chk("rst_err", 2, get_err(2), 0);

    // Clean run on the 1-lane, 2-vector checker.
    pulse_start(0);
    chk("t1_busy", 0, busy[0], 1);
    pair(0, 4'h1, 4'h0);
    pair(0, 4'h0, 4'h1);
    chk("t1_done", 0, done[0], 1);
    chk("t1_pass", 0, pass[0], 1);
    chk("t1_err", 0, get_err(0), 0);
    chk("t1_ffv", 0, ffv[0], 0);

    // First pair wrong, restarted straight from DONE.
    pulse_start(0);
    pair(0, 4'h1, 4'h1);
    if (ABORT) begin
      chk("t2_abort_done", 0, done[0], 1);
      chk("t2_abort_ready", 0, s_ready[0], 0);
    end
    pair(0, 4'h0, 4'h1);
    chk("t2_err", 0, get_err(0), 1);
    chk("t2_ffi", 0, get_ffi(0), 0);
    chk("t2_pass", 0, pass[0], 0);
    chk("t2_done", 0, done[0], 1);
    if (ABORT) chk("t2_ready_after", 0, s_ready[0], 0);

    // Four lanes, three vectors.
    pulse_start(1);
    pair(1, 4'hA, 4'h5);
    pair(1, 4'hF, 4'h1);
    pair(1, 4'h0, 4'hE);
    chk("t3_err", 1, get_err(1), ABORT ? 1 : 2);
    chk("t3_ffi", 1, get_ffi(1), 1);
    chk("t3_done", 1, done[1], 1);

    // rst and start together: rst wins.
    rst_t[1] = 1'b1; start_t[1] = 1'b1;
    cycle();
    rst_t[1] = 1'b0; start_t[1] = 1'b0;
    chk("t3_rst_busy", 1, busy[1], 0);
    chk("t3_rst_done", 1, done[1], 0);

    // Gapped valid, with start pulsed mid-run.
    pulse_start(0);
    pair(0, 4'h0, 4'h1);
    start_t[0] = 1'b1;
    cycle();
    start_t[0] = 1'b0;
    chk("t4_gap_done", 0, done[0], 0);
    chk("t4_gap_busy", 0, busy[0], 1);
    pair(0, 4'h1, 4'h0);
    chk("t4_done", 0, done[0], 1);
    chk("t4_pass", 0, pass[0], 1);

    // Reset mid-run, then a clean run.
    pulse_start(0);
    pair(0, 4'h1, 4'h0);
    rst_t[0] = 1'b1;
    cycle();
    rst_t[0] = 1'b0;
    chk("t5_busy", 0, busy[0], 0);
    chk("t5_ready", 0, s_ready[0], 0);
    chk("t5_done", 0, done[0], 0);
    pulse_start(0);
    pair(0, 4'h0, 4'h1);
    pair(0, 4'h1, 4'h0);
    chk("t5_pass", 0, pass[0], 1);

    // Narrow counters, every pair wrong.
    pulse_start(2);
    for (int i = 0; i < 3; i++) pair(2, 4'h0, 4'h0);
    chk("t6_err", 2, get_err(2), ABORT ? 1 : 3);
    chk("t6_done", 2, done[2], 1);
    pulse_start(2);
    chk("t6_restart_err", 2, get_err(2), 0);
    chk("t6_restart_busy", 2, busy[2], 1);
    for (int i = 0; i < 3; i++) pair(2, 4'h1, 4'h0);
    chk("t6_pass", 2, pass[2], 1);

    cycle();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/inv_resp_checker.md
# inv_resp_checker

- Synthesizable response checker for the inverter datapath; the receiving end of the stimulus/response exchange that a bench drives into the inverter.
- Accepts (stimulus, response) sample pairs over a valid/ready handshake and checks each response against the bitwise inverse of its stimulus.
- Counts mismatches and records the first failing sample index.
- Reports pass/fail when a fixed-length run completes, so inverter checks run in hardware or in a bench without hand-read `$display` output.

## Interface
- `WIDTH`, default 1: bits per stimulus/response sample (parallel inverter lanes).
- `NUM_VECTORS`, default 2: samples per run; legal range 1..2^CNT_W-1.
- `CNT_W`, default 8: width of index and error counters.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a run; sampled in IDLE and DONE only.
- `a_in`  in  WIDTH  stimulus value applied to the inverter.
- `y_in`  in  WIDTH  inverter response for `a_in`.
- `s_valid`  in  1  `a_in`/`y_in` pair valid.
- `s_ready`  out  1  checker accepts a pair this cycle.
- `busy`  out  1  run in progress.
- `done`  out  1  run complete; held until the next run starts or reset.
- `pass`  out  1  `done` and zero errors.
- `err_count`  out  CNT_W  mismatching samples this run, saturating.
- `first_fail_idx`  out  CNT_W  index of first mismatching sample.
- `first_fail_valid`  out  1  `first_fail_idx` is meaningful.

## Operation
- FSM states: IDLE, RUN, DONE. Reset drives IDLE and all outputs to 0.
- IDLE to RUN on `start`: clear `idx`, `err_count`, `first_fail_*`, `done`, `pass`.
- DONE to RUN on `start`: same clears, starting a new run.
- In RUN, `s_ready` = 1 and `busy` = 1. In IDLE and DONE, `s_ready` = 0.
- Accept: a pair is accepted when `s_valid` and `s_ready` are both high.
- Per accepted pair:
  - A pair mismatches when `y_in != ~a_in`; any single differing lane counts as one mismatch.
  - On mismatch, `err_count` increments and saturates at 2^CNT_W-1.
  - On the first mismatch of the run, `first_fail_idx` = `idx` and `first_fail_valid` = 1.
  - `idx` increments after every accepted pair.
- RUN to DONE on acceptance of sample NUM_VECTORS-1.
- In DONE: `done` = 1; `pass` = (`err_count` == 0); all counters hold.
- `start` asserted during RUN is ignored.
- `s_valid` in IDLE or DONE is ignored; nothing is consumed.

## Timing
- `s_ready` is a registered function of state only, with no combinational path from `s_valid`.
- `err_count` and `first_fail_*` update on the edge that accepts the pair (1-cycle latency).
- `done`, `pass`, and `busy` deassertion occur on the same edge that accepts the last sample.
- `busy` rises on the edge after `start` is sampled; the first accept is possible in that cycle.
- Back-to-back accepts are allowed at one pair per cycle, so a run takes a minimum of NUM_VECTORS cycles.
- `rst` mid-run: next edge returns to IDLE with all outputs 0; the partial run is discarded.
- `rst` and `start` asserted together: `rst` wins.

## Configuration
- `INV_CHK_ABORT_EN`:
  - Defined: the first mismatch moves RUN to DONE on that same edge. `err_count` = 1, `pass` = 0, and the remaining samples are not consumed (`s_ready` drops).
  - Undefined: all NUM_VECTORS samples are always consumed and every mismatch is counted.

## Test plan
- Defaults, `start`, then pairs (a=1,y=0),(a=0,y=1) -> `done`=1, `pass`=1, `err_count`=0, `first_fail_valid`=0, two cycles after `busy` rises.
- Defaults, pairs (a=1,y=1),(a=0,y=1):
  - Without macro -> `err_count`=1, `first_fail_idx`=0, `pass`=0.
  - With `INV_CHK_ABORT_EN` -> `done` after the first pair and `s_ready`=0 thereafter.
- WIDTH=4, NUM_VECTORS=3, pairs (4'hA,4'h5),(4'hF,4'h1),(4'h0,4'hE) -> `err_count`=2, `first_fail_idx`=1.
- `s_valid` toggling 1,0,1 in RUN -> only valid cycles counted; `done` after the second accept.
- `rst` after one accepted sample -> IDLE, all outputs 0; a fresh run then passes normally.
- CNT_W=2, NUM_VECTORS=3, all pairs mismatching -> `err_count`=3 (saturated at 2^CNT_W-1); `start` from DONE clears and restarts.
